// File: rtl/pixel_frame_packer.sv
// pixel_frame_packer: captures 4-pixel frames from read strobes and streams them as 5-byte packets (clk/reset, read1..4+pixData in, status_clr, out_valid/ready/data/first/last, overflow/sync_err)
module pixel_frame_packer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       read1,
  input  logic       read2,
  input  logic       read3,
  input  logic       read4,
  input  logic [7:0] pixData,
  input  logic       status_clr,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_first,
  output logic       out_last,
  output logic       overflow,
  output logic       sync_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, GOT1, GOT2, GOT3} state_t;
  state_t state, state_n;
  logic [3:0] s, exp_s, held_s;
  logic ok, viol, cap1, cap2, cap3, done;
  logic [7:0] p1, p2, p3, frame_id;
  logic [4:0][7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [2:0] idx;
  logic push, pop, acc;
  assign s = {read4, read3, read2, read1};
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // exp_s is the strobe that advances the frame, held_s the one just captured (re-sampling allowed)
  always_comb begin
    exp_s = 4'b0001 << state;
    held_s = state == IDLE ? 4'b0000 : 4'b0001 << (state - 2'd1);
    ok = s != 4'b0000 && (s & (s - 4'd1)) == 4'b0000 && (s == exp_s || s == held_s);
    viol = s != 4'b0000 && !ok;
    state_n = s == 4'b0000 ? state :
              viol ? (s == 4'b0001 ? GOT1 : IDLE) :
              s == held_s ? state :
              state == GOT3 ? IDLE : state_t'(state + 2'd1);
  end
  // read1 alone always (re)starts or refreshes P1, even when it is a violation
  always_comb begin
    cap1 = s == 4'b0001;
    cap2 = s == 4'b0010 && ok;
    cap3 = s == 4'b0100 && ok;
    done = s == 4'b1000 && state == GOT3;
  end
  always_ff @(posedge clk) begin
    if (cap1) p1 <= pixData;
    if (cap2) p2 <= pixData;
    if (cap3) p3 <= pixData;
  end
  assign acc = out_valid && out_ready;
  assign pop = acc && idx == 3'd4;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push = done && (cnt != (AW+1)'(FIFO_DEPTH) || pop);
  always_ff @(posedge clk)
    if (push) mem[wp] <= {pixData, p3, p2, p1, frame_id};
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      idx <= '0;
      frame_id <= '0;
      overflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      idx <= !acc ? idx : idx == 3'd4 ? 3'd0 : idx + 3'd1;
      frame_id <= frame_id + 8'(done);
      overflow <= (done && !push) || (overflow && !status_clr);
      sync_err <= viol || (sync_err && !status_clr);
    end
  assign out_valid = cnt != '0;
  assign out_data = out_valid ? mem[rp][idx] : 8'h00;
  assign out_first = out_valid && idx == 3'd0;
  assign out_last = out_valid && idx == 3'd4;
endmodule

// File: tb/tb_pixel_frame_packer.sv
// tb_pixel_frame_packer: queue-based reference model with per-cycle comparison plus directed literal checks
module tb_pixel_frame_packer;
  localparam int D = 2;
  logic clk = 0, reset = 1, read1 = 0, read2 = 0, read3 = 0, read4 = 0;
  logic [7:0] pixData = 0;
  logic status_clr = 0, out_ready = 0;
  logic out_valid, out_first, out_last, overflow, sync_err;
  logic [7:0] out_data;
  pixel_frame_packer #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .read1(read1), .read2(read2), .read3(read3), .read4(read4),
    .pixData(pixData), .status_clr(status_clr), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_first(out_first), .out_last(out_last), .overflow(overflow),
    .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  int n = 0, idx = 0;
  logic [7:0] mp [1:3];
  logic [7:0] mid = 0;
  logic [39:0] q [$];
  bit movf = 0, mserr = 0;
  logic [7:0] acc [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic r1, r2, r3, r4, input logic [7:0] d, input logic rdy, clr, rst);
    bit pop, vio, done, oev;
    int k, c;
    logic [7:0] eb;
    @(negedge clk);
    eb = q.size() > 0 ? q[0][8*idx +: 8] : 8'h00;
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_data", out_data, eb);
    chk("out_first", out_first, q.size() > 0 && idx == 0);
    chk("out_last", out_last, q.size() > 0 && idx == 4);
    chk("overflow", overflow, movf);
    chk("sync_err", sync_err, mserr);
    if (out_valid && rdy && !rst) acc.push_back(out_data);
    read1 = r1; read2 = r2; read3 = r3; read4 = r4;
    pixData = d; out_ready = rdy; status_clr = clr; reset = rst;
    @(posedge clk);
    if (rst) begin
      n = 0; idx = 0; mid = 0; movf = 0; mserr = 0; q.delete();
    end else begin
      pop = q.size() > 0 && rdy && idx == 4;
      vio = 0; done = 0; oev = 0; k = 0;
      c = int'(r1) + int'(r2) + int'(r3) + int'(r4);
      if (c == 1) k = r1 ? 1 : r2 ? 2 : r3 ? 3 : 4;
      if (c > 1) begin
        vio = 1; n = 0;
      end else if (c == 1) begin
        if (k == n + 1 || (k == n && n > 0)) begin
          if (k == 4) begin done = 1; n = 0; end
          else begin mp[k] = d; n = k; end
        end else begin
          vio = 1;
          if (k == 1) begin mp[1] = d; n = 1; end else n = 0;
        end
      end
      if (q.size() > 0 && rdy) idx = idx == 4 ? 0 : idx + 1;
      if (pop) void'(q.pop_front());
      if (done) begin
        if (q.size() < D) q.push_back({d, mp[3], mp[2], mp[1], mid});
        else oev = 1;
        mid++;
      end
      movf = oev || (movf && !clr);
      mserr = vio || (mserr && !clr);
    end
  endtask
  task automatic idle(input int cyc, input logic rdy);
    for (int i = 0; i < cyc; i++) step(0, 0, 0, 0, 8'h00, rdy, 0, 0);
  endtask
  task automatic frame(input logic [7:0] a, b, c, e, input logic rdy);
    step(1, 0, 0, 0, a, rdy, 0, 0);
    step(0, 1, 0, 0, b, rdy, 0, 0);
    step(0, 0, 1, 0, c, rdy, 0, 0);
    step(0, 0, 0, 1, e, rdy, 0, 0);
  endtask
  initial begin
    logic [3:0] rs;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    // basic frame
    acc.delete();
    frame(8'h11, 8'h22, 8'h33, 8'h44, 1);
    #1 chk("lat1_valid", out_valid, 1);
    chk("lat1_first", out_first, 1);
    chk("lat1_hdr", out_data, 8'h00);
    idle(6, 1);
    chk("basic_len", acc.size(), 5);
    if (acc.size() == 5) begin
      chk("basic_b0", acc[0], 8'h00);
      chk("basic_b1", acc[1], 8'h11);
      chk("basic_b2", acc[2], 8'h22);
      chk("basic_b3", acc[3], 8'h33);
      chk("basic_b4", acc[4], 8'h44);
    end
    // backpressure: ready toggles, 10 cycles to drain
    acc.delete();
    frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, i[0], 0, 0);
    #1 chk("bp_drained", out_valid, 0);
    chk("bp_len", acc.size(), 5);
    if (acc.size() == 5) begin
      chk("bp_hdr", acc[0], 8'h01);
      chk("bp_b4", acc[4], 8'h44);
    end
    // overflow
    step(0, 0, 0, 0, 0, 0, 0, 1);
    acc.delete();
    frame(8'hA1, 8'hA2, 8'hA3, 8'hA4, 0);
    frame(8'hB1, 8'hB2, 8'hB3, 8'hB4, 0);
    frame(8'hC1, 8'hC2, 8'hC3, 8'hC4, 0);
    #1 chk("ovf_set", overflow, 1);
    idle(11, 1);
    frame(8'hD1, 8'hD2, 8'hD3, 8'hD4, 1);
    idle(6, 1);
    chk("ovf_len", acc.size(), 15);
    if (acc.size() == 15) begin
      chk("ovf_h0", acc[0], 8'h00);
      chk("ovf_h1", acc[5], 8'h01);
      chk("ovf_h3", acc[10], 8'h03);
      chk("ovf_p1", acc[11], 8'hD1);
    end
    // sync error
    step(0, 0, 0, 0, 0, 0, 0, 1);
    acc.delete();
    step(1, 0, 0, 0, 8'hAA, 1, 0, 0);
    step(0, 0, 1, 0, 8'hBB, 1, 0, 0);
    frame(8'h01, 8'h02, 8'h03, 8'h04, 1);
    idle(6, 1);
    chk("sync_flag", sync_err, 1);
    chk("sync_len", acc.size(), 5);
    if (acc.size() == 5) begin
      chk("sync_hdr", acc[0], 8'h00);
      chk("sync_p1", acc[1], 8'h01);
    end
    // simultaneous strobes, then status clear
    acc.delete();
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 1, 0, 0, 8'h55, 1, 0, 0);
    #1 chk("multi_flag", sync_err, 1);
    step(0, 0, 1, 0, 8'h66, 1, 0, 0);
    step(0, 0, 0, 1, 8'h77, 1, 0, 0);
    idle(3, 1);
    chk("multi_nopkt", acc.size(), 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    #1 chk("clr_flag", sync_err, 0);
    step(0, 1, 0, 0, 8'h00, 1, 1, 0);
    #1 chk("clr_vs_event", sync_err, 1);
    // reset mid-packet, then id wrap
    frame(8'h91, 8'h92, 8'h93, 8'h94, 1);
    idle(3, 1);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    #1 chk("rst_mid_valid", out_valid, 0);
    acc.delete();
    for (int f = 0; f < 257; f++) begin
      frame(8'(f), 8'h5A, 8'hA5, 8'h3C, 1);
      idle(1, 1);
    end
    idle(6, 1);
    chk("wrap_len", acc.size(), 257 * 5);
    if (acc.size() == 257 * 5) begin
      chk("wrap_h0", acc[0], 8'h00);
      chk("wrap_h255", acc[255*5], 8'hFF);
      chk("wrap_h256", acc[256*5], 8'h00);
    end
    // randomized, mostly well-formed strobe sequences
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      rs = 4'b0000;
      if (r >= 50 && r < 80) rs = 4'b0001 << (n == 3 ? 3 : n);
      else if (r >= 80 && r < 90) rs = n == 0 ? 4'b0001 : 4'b0001 << (n - 1);
      else if (r >= 90) rs = 4'($urandom_range(0, 15));
      step(rs[0], rs[1], rs[2], rs[3], 8'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0);
    end
    idle(12, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
